// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch and PC sequencer feeding the control decoder.
// Fetches one word per instruction over a req/ack handshake and computes the next PC on retire.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [5:0]  BUBBLE_OP = 6'b111111
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        retire,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic        valid_reg, valid_next;
  logic        launched_reg, launched_next;

  logic [31:0] branch_off;
  logic        branch_taken;
  logic [31:0] retire_target;

  assign pc_plus4     = pc_reg + 32'd4;
  assign branch_off   = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
  // instr[28] distinguishes bne (taken on !zero) from beq (taken on zero)
  assign branch_taken = branch & (instr_reg[28] ? ~zero : zero);

  always_comb begin
    retire_target = pc_plus4;
    if (jump) begin
      retire_target = {pc_plus4[31:28], instr_reg[25:0], 2'b00};
    end else if (branch_taken) begin
      retire_target = pc_plus4 + branch_off;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_RST;
      pc_reg       <= RESET_PC;
      instr_reg    <= 32'd0;
      valid_reg    <= 1'b0;
      launched_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      instr_reg    <= instr_next;
      valid_reg    <= valid_next;
      launched_reg <= launched_next;
    end
  end

  // Once the request is launched it stays up regardless of stall until acked
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    valid_next    = valid_reg;
    launched_next = launched_reg;
    imem_req      = 1'b0;
    case (state_reg)
      ST_RST: begin
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = launched_reg | ~stall;
        if (imem_req) begin
          if (imem_ack) begin
            instr_next    = imem_rdata;
            valid_next    = 1'b1;
            launched_next = 1'b0;
            state_next    = ST_ISSUE;
          end else begin
            launched_next = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (retire && !stall) begin
          pc_next    = retire_target;
          valid_next = 1'b0;
          state_next = ST_FETCH;
        end
      end
      default: begin
        state_next = ST_RST;
      end
    endcase
  end

  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign instr       = instr_reg;
  assign instr_valid = valid_reg;
  assign opcode      = valid_reg ? instr_reg[31:26] : BUBBLE_OP;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle behavioural model checked every negedge,
// plus literal expectations for reset, sequential/branch/jump targets, stall and reset abort.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [5:0]  BUBBLE_OP = 6'b111111;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        retire;
  logic        branch;
  logic        jump;
  logic        zero;
  logic        stall;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .BUBBLE_OP(BUBBLE_OP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .retire(retire), .branch(branch), .jump(jump), .zero(zero), .stall(stall),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = waiting after reset, 1 = fetching, 2 = holding an instruction
  int          m_phase;
  logic [31:0] m_pc, m_instr;
  logic        m_valid, m_req_up;
  logic        m_req;
  assign m_req = (m_phase == 1) && (m_req_up || !stall);

  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
                                             input logic br, input logic jp, input logic z);
    logic [31:0] seq;
    int          off;
    logic        taken;
    seq   = p + 32'd4;
    off   = int'($signed(ins[15:0])) * 4;
    taken = ins[28] ? !z : z;
    if (jp) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
    if (br && taken) return seq + 32'(off);
    return seq;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase  <= 0;
      m_pc     <= RESET_PC;
      m_instr  <= 32'd0;
      m_valid  <= 1'b0;
      m_req_up <= 1'b0;
    end else begin
      case (m_phase)
        0: m_phase <= 1;
        1: if (m_req) begin
             if (imem_ack) begin
               m_instr  <= imem_rdata;
               m_valid  <= 1'b1;
               m_req_up <= 1'b0;
               m_phase  <= 2;
             end else begin
               m_req_up <= 1'b1;
             end
           end
        default: if (retire && !stall) begin
             m_pc    <= model_next(m_pc, m_instr, branch, jump, zero);
             m_valid <= 1'b0;
             m_phase <= 1;
           end
      endcase
    end
  end

  always @(negedge clk) begin
    check("model_req", imem_req, m_req);
    check("model_addr", imem_addr, m_pc);
    check("model_pc", pc, m_pc);
    check("model_pc_plus4", pc_plus4, m_pc + 32'd4);
    check("model_instr", instr, m_instr);
    check("model_valid", instr_valid, m_valid);
    check("model_opcode", opcode, m_valid ? m_instr[31:26] : BUBBLE_OP);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    check("req_timeout", imem_req, 1'b1);
  endtask

  task automatic do_fetch(input logic [31:0] word, input int lat);
    wait_req();
    repeat (lat) tick();
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    check("fetched_valid", instr_valid, 1'b1);
    check("fetched_instr", instr, word);
  endtask

  task automatic xact(input logic [31:0] word, input logic br, input logic jp, input logic z,
                      input int lat, input logic [31:0] exp_pc);
    logic [31:0] from_pc;
    do_fetch(word, lat);
    from_pc = pc;
    branch  = br;
    jump    = jp;
    zero    = z;
    retire  = 1'b1;
    tick();
    retire = 1'b0;
    branch = 1'b0;
    jump   = 1'b0;
    zero   = 1'b0;
    check("next_pc", pc, exp_pc);
    check("next_fetch_addr", imem_addr, exp_pc);
    check("valid_low_in_fetch", instr_valid, 1'b0);
    $display("xact pc=%h instr=%h br=%0b j=%0b z=%0b -> pc=%h", from_pc, word, br, jp, z, pc);
  endtask

  typedef struct {
    logic [31:0] word;
    logic        br, jp, z;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$] = '{
    '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0008},
    '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_000C},
    '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0010},
    '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0014},
    '{32'h0800_0010, 1'b0, 1'b1, 1'b0, 32'h0000_0040},
    '{32'h8C22_FFFE, 1'b1, 1'b0, 1'b1, 32'h0000_003C},
    '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0040},
    '{32'h8C22_FFFE, 1'b1, 1'b0, 1'b0, 32'h0000_0044},
    '{32'h0800_0010, 1'b0, 1'b1, 1'b0, 32'h0000_0040},
    '{32'h9C22_FFFE, 1'b1, 1'b0, 1'b0, 32'h0000_003C},
    '{32'h9C22_FFFE, 1'b1, 1'b0, 1'b1, 32'h0000_0040},
    '{32'h0BFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h0FFF_FFFC},
    '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h1000_0000},
    '{32'h0800_0008, 1'b0, 1'b1, 1'b0, 32'h1000_0020},
    '{32'hE000_0100, 1'b0, 1'b1, 1'b0, 32'h1000_0400},
    '{32'h0800_0008, 1'b0, 1'b1, 1'b0, 32'h1000_0020},
    '{32'hE000_0100, 1'b1, 1'b1, 1'b1, 32'h1000_0400}
  };

  initial begin
    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    retire     = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    zero       = 1'b0;
    stall      = 1'b0;
    tick();
    tick();
    check("reset_req", imem_req, 1'b0);
    check("reset_opcode", opcode, 32'h3F);
    check("reset_pc", pc, 32'h0);
    rst_n = 1'b1;

    // First fetch with a 2-cycle memory latency
    wait_req();
    check("first_addr", imem_addr, 32'h0);
    check("bubble_before_ack", opcode, 32'h3F);
    do_fetch(32'h0800_0004, 2);
    check("first_opcode", opcode, 32'h02);
    retire = 1'b1;
    tick();
    retire = 1'b0;
    check("seq_pc", pc, 32'h4);

    foreach (vecs[i]) xact(vecs[i].word, vecs[i].br, vecs[i].jp, vecs[i].z, i % 3, vecs[i].exp_pc);

    // Stall blocks retire for 3 cycles; a stray ack in ISSUE is ignored
    do_fetch(32'h0000_0000, 1);
    stall  = 1'b1;
    retire = 1'b1;
    repeat (3) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hFFFF_FFFF;
      tick();
      check("stall_pc_hold", pc, 32'h1000_0400);
      check("stall_no_req", imem_req, 1'b0);
      check("stall_instr_hold", instr, 32'h0);
    end
    imem_ack = 1'b0;
    stall    = 1'b0;
    tick();
    retire = 1'b0;
    stall  = 1'b1;
    check("stall_release_pc", pc, 32'h1000_0404);
    repeat (2) begin
      tick();
      check("stall_delays_req", imem_req, 1'b0);
    end
    stall = 1'b0;
    #1;
    check("req_after_stall", imem_req, 1'b1);
    tick();
    stall = 1'b1;
    #1;
    check("req_held_under_stall", imem_req, 1'b1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0000;
    tick();
    imem_ack = 1'b0;
    stall    = 1'b0;
    check("stalled_fetch_valid", instr_valid, 1'b1);
    retire = 1'b1;
    tick();
    retire = 1'b0;
    check("post_stall_pc", pc, 32'h1000_0408);

    // Reset while a fetch is outstanding
    wait_req();
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_req", imem_req, 1'b0);
    check("abort_pc", pc, RESET_PC);
    check("abort_opcode", opcode, 32'h3F);
    tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    rst_n = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("late_ack_ignored", instr, 32'h0);
    check("restart_addr", imem_addr, RESET_PC);
    check("restart_req", imem_req, 1'b1);

    // Backward branch from 0 wraps to the top of the address space, then pc+4 wraps to 0
    xact(32'h8C22_FFFE, 1'b1, 1'b0, 1'b1, 0, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", pc_plus4, 32'h0);
    xact(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1, 32'h0000_0000);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
